// File: rtl/srlfifo_ctl.sv
// Control and registered output stage around a 64x8 addressable shift register.
// Together with the SRL this forms a 65-byte FIFO: 64 SRL stages plus the q register.
module srlfifo_ctl (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr,
    input  logic [7:0] wd,
    output logic [7:0] sd,
    output logic       sce,
    output logic [5:0] sa,
    input  logic [7:0] sy,
    output logic [7:0] q,
    output logic       qv,
    input  logic       qr,
    output logic [6:0] lvl,
    output logic       full,
    output logic       empty,
    output logic       ovf
);

    logic [6:0] cnt;
    logic [6:0] cnt_m1;
    logic       nz;
    logic       push;
    logic       ld;

    assign nz     = (cnt != 7'd0);
    assign cnt_m1 = cnt - 7'd1;
    assign full   = (cnt == 7'd64);
    assign empty  = ~nz & ~qv;
    assign lvl    = cnt;

    assign push = wr & ~full;
    // Load q from the oldest entry when the output slot is free or being drained.
    assign ld   = nz & (~qv | qr);

    assign sd  = wd;
    assign sce = push & ~rst;
    // cnt-1 is at most 63 here, so the low six bits are the full address.
    assign sa  = nz ? cnt_m1[5:0] : 6'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 7'd0;
            qv  <= 1'b0;
            q   <= 8'h00;
            ovf <= 1'b0;
        end else begin
            if (ld) begin
                q  <= sy;
                qv <= 1'b1;
            end else if (qv & qr) begin
                qv <= 1'b0;
            end

            if (push & ~ld)
                cnt <= cnt + 7'd1;
            else if (ld & ~push)
                cnt <= cnt_m1;

            if (wr & full)
                ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_srlfifo_ctl.sv
// Bench for srlfifo_ctl: a behavioural 64x8 SRL closes the sa/sy loop,
// a vector table covers the basic cases and hand sequences cover fill/drain/reset.
module tb_srlfifo_ctl;

    logic       clk = 1'b0;
    logic       rst, wr, qr;
    logic [7:0] wd, sd, sy, q;
    logic       sce, qv, full, empty, ovf;
    logic [5:0] sa;
    logic [6:0] lvl;

    int ntests = 0;
    int nfail  = 0;

    srlfifo_ctl dut (
        .clk(clk), .rst(rst), .wr(wr), .wd(wd), .sd(sd), .sce(sce), .sa(sa),
        .sy(sy), .q(q), .qv(qv), .qr(qr), .lvl(lvl), .full(full),
        .empty(empty), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // External shift register: newest at address 0, read combinationally.
    logic [7:0] srl [0:63];
    always @(posedge clk) begin
        if (sce) begin
            srl[0] <= sd;
            for (int i = 63; i > 0; i--) srl[i] <= srl[i-1];
        end
    end
    assign sy = srl[sa];

    typedef struct {
        logic       r;
        logic       w;
        logic [7:0] d;
        logic       rdy;
        logic       esce;
        logic [7:0] eq;
        logic       eqv;
        logic [6:0] elvl;
        logic       efull;
        logic       eempty;
        logic       eovf;
    } vec_t;

    vec_t tv [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [7:0] d, input logic rdy);
        rst = r; wr = w; wd = d; qr = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " q"},     q,     8'h00);
        chk({tag, " qv"},    qv,    1'b0);
        chk({tag, " lvl"},   lvl,   7'd0);
        chk({tag, " full"},  full,  1'b0);
        chk({tag, " empty"}, empty, 1'b1);
        chk({tag, " ovf"},   ovf,   1'b0);
        chk({tag, " sa"},    sa,    6'd0);
    endtask

    initial begin
        //           r  w  d      qr sce q      qv lvl    full empty ovf
        tv[0] = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0};
        tv[1] = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0};
        tv[2] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, 7'd1, 1'b0, 1'b0, 1'b0};
        tv[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b1, 7'd0, 1'b0, 1'b0, 1'b0};
        tv[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0};
        tv[5] = '{1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 8'hA5, 1'b0, 7'd1, 1'b0, 1'b0, 1'b0};
        tv[6] = '{1'b0, 1'b1, 8'h04, 1'b0, 1'b1, 8'h03, 1'b1, 7'd1, 1'b0, 1'b0, 1'b0};
        tv[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h03, 1'b1, 7'd1, 1'b0, 1'b0, 1'b0};
        tv[8] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h04, 1'b1, 7'd0, 1'b0, 1'b0, 1'b0};
        tv[9] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h04, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0};

        for (int i = 0; i < 10; i++) begin
            drive(tv[i].r, tv[i].w, tv[i].d, tv[i].rdy);
            chk($sformatf("v%0d sce", i), sce, tv[i].esce);
            tick();
            chk($sformatf("v%0d q", i),     q,     tv[i].eq);
            chk($sformatf("v%0d qv", i),    qv,    tv[i].eqv);
            chk($sformatf("v%0d lvl", i),   lvl,   tv[i].elvl);
            chk($sformatf("v%0d full", i),  full,  tv[i].efull);
            chk($sformatf("v%0d empty", i), empty, tv[i].eempty);
            chk($sformatf("v%0d ovf", i),   ovf,   tv[i].eovf);
        end

        // Fill: 65 bytes 00..40 with consumer stalled.
        for (int i = 0; i <= 64; i++) begin
            drive(1'b0, 1'b1, 8'(i), 1'b0);
            tick();
        end
        chk("fill q",    q,    8'h00);
        chk("fill qv",   qv,   1'b1);
        chk("fill lvl",  lvl,  7'd64);
        chk("fill full", full, 1'b1);
        chk("fill sa",   sa,   6'd63);
        chk("fill ovf",  ovf,  1'b0);

        // Write while full is dropped.
        drive(1'b0, 1'b1, 8'hFF, 1'b0);
        chk("ovf sce", sce, 1'b0);
        tick();
        chk("ovf flag", ovf, 1'b1);
        chk("ovf lvl",  lvl, 7'd64);
        chk("ovf q",    q,   8'h00);

        // Drain in order.
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 1; i <= 64; i++) begin
            tick();
            chk($sformatf("drain q%0d", i), q, 8'(i));
            chk($sformatf("drain qv%0d", i), qv, 1'b1);
            chk($sformatf("drain lvl%0d", i), lvl, 7'(64 - i));
        end
        tick();
        chk("drain empty", empty, 1'b1);
        chk("drain qv",    qv,    1'b0);
        chk("drain q",     q,     8'h40);

        // Simultaneous push/pop at lvl=10.
        for (int i = 0; i < 11; i++) begin
            drive(1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
            tick();
        end
        chk("sim pre lvl", lvl, 7'd10);
        chk("sim pre q",   q,   8'h80);
        chk("sim pre qv",  qv,  1'b1);
        for (int j = 0; j < 20; j++) begin
            drive(1'b0, 1'b1, 8'(8'h8B + j), 1'b1);
            chk($sformatf("sim sce%0d", j), sce, 1'b1);
            tick();
            chk($sformatf("sim lvl%0d", j), lvl, 7'd10);
            chk($sformatf("sim q%0d", j),   q,   8'(8'h81 + j));
            chk($sformatf("sim qv%0d", j),  qv,  1'b1);
        end

        // Reset mid-operation at lvl=30.
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
            tick();
        end
        chk("mid lvl", lvl, 7'd30);
        chk("mid qv",  qv,  1'b1);
        drive(1'b1, 1'b1, 8'hEE, 1'b0);
        chk("mid sce", sce, 1'b0);
        tick();
        chk_reset("mid rst");

        drive(1'b0, 1'b1, 8'h3C, 1'b1);
        tick();
        chk("post lvl1", lvl, 7'd1);
        chk("post qv1",  qv,  1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        chk("post q",    q,   8'h3C);
        chk("post qv2",  qv,  1'b1);
        chk("post lvl2", lvl, 7'd0);
        tick();
        chk("post qv3",   qv,    1'b0);
        chk("post empty", empty, 1'b1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
